// File: rtl/sbh_parity_adjust.sv
// Sign-bit-hiding parity adjustment for one coefficient group.
// Levels and deltas are buffered in raster order, scanned in reverse scan
// order to find the cheapest single +/-1 magnitude change, then, if the
// level parity disagrees with the hidden sign, that change is applied before
// the group is streamed out in raster order.
module sbh_parity_adjust #(
   parameter int COEFF_W    = 16,
   parameter int DELTA_W    = 16,
   parameter int CG_SIZE    = 16,
   parameter int SBH_THRESH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_in,
   input  logic signed [COEFF_W-1:0]  coef_in,
   input  logic signed [DELTA_W-1:0]  delta_in,
   input  logic [3:0]                 position_in,
   input  logic                       load_done,
   input  logic [15:0][3:0]           scan_order,
   input  logic                       nz_valid,
   input  logic [3:0]                 firstNZ,
   input  logic [3:0]                 lastNZ,
   input  logic                       hasNZ,
   output logic                       in_ready,
   output logic signed [COEFF_W-1:0]  coef_out,
   output logic [3:0]                 pos_out,
   output logic                       valid_out,
   output logic                       last_out,
   output logic                       sbh_flag,
   input  logic                       out_ready
);

   localparam int COST_W = DELTA_W + 1;
   localparam logic signed [COST_W-1:0] COST_MAX = {1'b0, {(COST_W-1){1'b1}}};
   localparam logic [COEFF_W-1:0]       MAG_MAX  = {1'b0, {(COEFF_W-1){1'b1}}};
   localparam logic [3:0]               THRESH   = 4'(SBH_THRESH);

   typedef enum logic [2:0] {LOAD, WAIT_NZ, SCAN, ADJUST, OUTPUT} state_t;

   state_t state, state_nxt;

   logic signed [COEFF_W-1:0] coef_mem  [CG_SIZE];
   logic signed [DELTA_W-1:0] delta_mem [CG_SIZE];

   logic [3:0]               first_nz, last_nz;
   logic                     has_nz;
   logic [3:0]               scan_idx;
   logic                     parity;
   logic                     hid_sign;
   logic signed [COST_W-1:0] best_cost;
   logic [3:0]               best_pos;
   logic                     best_up;
   logic [3:0]               out_pos;

   logic [3:0]                scan_pos;
   logic signed [COEFF_W-1:0] cur_lvl;
   logic signed [DELTA_W-1:0] cur_dlt;
   logic signed [COST_W-1:0]  cur_cost;
   logic [3:0]                nz_span;
   logic                      sbh_en;
   logic                      mismatch;

   // Magnitude of a level; the most negative level maps to 2^(COEFF_W-1).
   function automatic logic [COEFF_W-1:0] mag_of(input logic signed [COEFF_W-1:0] lvl);
      mag_of = lvl[COEFF_W-1] ? (~lvl + 1'b1) : lvl;
   endfunction

   // Rate cost of nudging one level by +/-1. Elements that must not move
   // (zero, beyond lastNZ, lone +/-1 at firstNZ, or would overflow) get MAX.
   function automatic logic signed [COST_W-1:0] cost_of(
      input logic signed [COEFF_W-1:0] lvl,
      input logic signed [DELTA_W-1:0] dlt,
      input logic                      is_first,
      input logic                      in_range
   );
      logic [COEFF_W-1:0]       mag;
      logic signed [COST_W-1:0] dext;
      mag  = mag_of(lvl);
      dext = {dlt[DELTA_W-1], dlt};
      if (mag == '0 || !in_range)
         cost_of = COST_MAX;
      else if (is_first && mag == COEFF_W'(1))
         cost_of = COST_MAX;
      else if (dlt > 0)
         cost_of = (mag >= MAG_MAX) ? COST_MAX : -dext;
      else
         cost_of = dext;
   endfunction

   // Apply a +/-1 magnitude step while keeping the original sign.
   function automatic logic signed [COEFF_W-1:0] step_mag(
      input logic signed [COEFF_W-1:0] lvl,
      input logic                      up
   );
      logic [COEFF_W-1:0] mag, nmag;
      mag      = mag_of(lvl);
      nmag     = up ? (mag + 1'b1) : (mag - 1'b1);
      step_mag = lvl[COEFF_W-1] ? $signed(~nmag + 1'b1) : $signed(nmag);
   endfunction

   assign scan_pos = scan_order[scan_idx];
   assign cur_lvl  = coef_mem[scan_pos];
   assign cur_dlt  = delta_mem[scan_pos];
   assign cur_cost = cost_of(cur_lvl, cur_dlt, scan_idx == first_nz, scan_idx <= last_nz);

   // The span is a wrapping 4-bit difference, only meaningful once hasNZ is set.
   assign nz_span  = last_nz - first_nz;
   assign sbh_en   = has_nz && (nz_span >= THRESH);
   assign mismatch = sbh_en && (parity != hid_sign);

   assign in_ready  = (state == LOAD);
   assign valid_out = (state == OUTPUT);
   assign last_out  = valid_out && (out_pos == 4'd15);
   assign pos_out   = valid_out ? out_pos : 4'd0;
   assign coef_out  = valid_out ? coef_mem[out_pos] : '0;
   assign sbh_flag  = valid_out && sbh_en;

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= LOAD;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (load_done)                          state_nxt = WAIT_NZ;
         WAIT_NZ: if (nz_valid)                           state_nxt = SCAN;
         SCAN:    if (scan_idx == 4'd0)                   state_nxt = ADJUST;
         ADJUST:                                          state_nxt = OUTPUT;
         OUTPUT:  if (out_ready && out_pos == 4'd15)      state_nxt = LOAD;
         default:                                         state_nxt = LOAD;
      endcase
   end

   // Group storage, NZ capture, scan accumulation, adjustment and beat counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CG_SIZE; i++) begin
            coef_mem[i]  <= '0;
            delta_mem[i] <= '0;
         end
         first_nz  <= '0;
         last_nz   <= '0;
         has_nz    <= 1'b0;
         scan_idx  <= '0;
         parity    <= 1'b0;
         hid_sign  <= 1'b0;
         best_cost <= COST_MAX;
         best_pos  <= '0;
         best_up   <= 1'b0;
         out_pos   <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (valid_in) begin
                  coef_mem[position_in]  <= coef_in;
                  delta_mem[position_in] <= delta_in;
               end
            end
            WAIT_NZ: begin
               if (nz_valid) begin
                  first_nz  <= firstNZ;
                  last_nz   <= lastNZ;
                  has_nz    <= hasNZ;
                  scan_idx  <= 4'd15;
                  parity    <= 1'b0;
                  hid_sign  <= 1'b0;
                  best_cost <= COST_MAX;
                  best_pos  <= '0;
                  best_up   <= 1'b0;
                  out_pos   <= '0;
               end
            end
            SCAN: begin
               // Bit 0 of |level| equals bit 0 of the two's-complement level.
               parity <= parity ^ cur_lvl[0];
               if (scan_idx == first_nz)
                  hid_sign <= cur_lvl[COEFF_W-1];
               // Strict compare: on a tie the earlier-visited (higher) scan index wins.
               if (cur_cost < best_cost) begin
                  best_cost <= cur_cost;
                  best_pos  <= scan_pos;
                  best_up   <= (cur_dlt > 0);
               end
               scan_idx <= scan_idx - 4'd1;
            end
            ADJUST: begin
               if (mismatch && best_cost != COST_MAX)
                  coef_mem[best_pos] <= step_mag(coef_mem[best_pos], best_up);
            end
            OUTPUT: begin
               if (out_ready)
                  out_pos <= out_pos + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sbh_parity_adjust.sv
// Scoreboard bench for sbh_parity_adjust: directed groups push expected
// beats; an independent monitor pops and compares each accepted beat.
module tb_sbh_parity_adjust;

   logic                clk = 1'b0;
   logic                rst;
   logic                valid_in;
   logic signed [15:0]  coef_in;
   logic signed [15:0]  delta_in;
   logic [3:0]          position_in;
   logic                load_done;
   logic [15:0][3:0]    scan_order;
   logic                nz_valid;
   logic [3:0]          firstNZ, lastNZ;
   logic                hasNZ;
   logic                in_ready;
   logic signed [15:0]  coef_out;
   logic [3:0]          pos_out;
   logic                valid_out, last_out, sbh_flag;
   logic                out_ready;

   sbh_parity_adjust #(.COEFF_W(16), .DELTA_W(16), .CG_SIZE(16), .SBH_THRESH(4)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .coef_in(coef_in), .delta_in(delta_in),
      .position_in(position_in), .load_done(load_done), .scan_order(scan_order),
      .nz_valid(nz_valid), .firstNZ(firstNZ), .lastNZ(lastNZ), .hasNZ(hasNZ),
      .in_ready(in_ready), .coef_out(coef_out), .pos_out(pos_out), .valid_out(valid_out),
      .last_out(last_out), .sbh_flag(sbh_flag), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [15:0] coef;
      logic [3:0]         pos;
      logic               last;
      logic               flag;
   } beat_t;

   beat_t exp_q[$];
   int    n_cmp  = 0;
   int    n_fail = 0;
   int    cnt    = 0;
   int    t_nz   = 0;
   bit    lat_armed = 1'b0;

   logic signed [15:0] lv[16];
   logic signed [15:0] dl[16];
   logic signed [15:0] ex[16];

   always @(posedge clk) cnt <= cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: compares every presented beat against the scoreboard head.
   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         if (!rst && valid_out) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 32'(pos_out), 32'hFFFF);
            end else begin
               if (lat_armed) begin
                  check("latency", 32'(cnt - t_nz), 32'd18);
                  lat_armed = 1'b0;
               end
               b = exp_q[0];
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  check($sformatf("beat_pos%0d", b.pos),
                        32'({coef_out, pos_out, last_out, sbh_flag}),
                        32'({b.coef, b.pos, b.last, b.flag}));
               end else begin
                  check("hold_beat",
                        32'({coef_out, pos_out, last_out, sbh_flag}),
                        32'({b.coef, b.pos, b.last, b.flag}));
               end
            end
         end
      end
   end

   task automatic clear_vec();
      for (int i = 0; i < 16; i++) begin
         lv[i] = '0;
         dl[i] = '0;
      end
   endtask

   task automatic ex_from_lv();
      for (int i = 0; i < 16; i++) ex[i] = lv[i];
   endtask

   task automatic write_all();
      for (int i = 0; i < 16; i++) begin
         valid_in    = 1'b1;
         position_in = 4'(i);
         coef_in     = lv[i];
         delta_in    = dl[i];
         load_done   = (i == 15);
         @(posedge clk); #1;
      end
      valid_in  = 1'b0;
      load_done = 1'b0;
   endtask

   task automatic write_one(input logic [3:0] p, input logic signed [15:0] c,
                            input logic signed [15:0] d);
      valid_in = 1'b1; position_in = p; coef_in = c; delta_in = d; load_done = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0; load_done = 1'b0;
   endtask

   task automatic just_done();
      load_done = 1'b1;
      @(posedge clk); #1;
      load_done = 1'b0;
   endtask

   task automatic start_group(input logic [3:0] f, input logic [3:0] l,
                              input logic h, input logic flag);
      beat_t b;
      for (int i = 0; i < 16; i++) begin
         b.coef = ex[i]; b.pos = 4'(i); b.last = (i == 15); b.flag = flag;
         exp_q.push_back(b);
      end
      nz_valid = 1'b1; firstNZ = f; lastNZ = l; hasNZ = h;
      t_nz = cnt; lat_armed = 1'b1;
      @(posedge clk); #1;
      nz_valid = 1'b0; firstNZ = 4'd0; lastNZ = 4'd0; hasNZ = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         lat_armed = 1'b0;
      end else begin
         check("in_ready_after_group", 32'(in_ready), 32'd1);
      end
   endtask

   task automatic wait_beat(input logic [3:0] p);
      int k = 0;
      while (!(valid_out && pos_out == p) && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) check("wait_beat_timeout", 32'(pos_out), 32'(p));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; valid_in = 1'b0; coef_in = '0; delta_in = '0; position_in = '0;
      load_done = 1'b0; nz_valid = 1'b0; firstNZ = '0; lastNZ = '0; hasNZ = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) scan_order[i] = 4'(i);
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_valid_out", 32'(valid_out), 32'd0);
      check("rst_last_out",  32'(last_out),  32'd0);
      check("rst_sbh_flag",  32'(sbh_flag),  32'd0);
      check("rst_coef_out",  32'(coef_out),  32'd0);
      check("rst_pos_out",   32'(pos_out),   32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // All-zero group, hasNZ=0.
      clear_vec(); ex_from_lv();
      write_all();
      start_group(4'd0, 4'd0, 1'b0, 1'b0);
      drain();

      // Span 3 below threshold: odd parity left alone; write during SCAN ignored.
      clear_vec();
      lv[2] = 16'sd1; lv[5] = 16'sd2; dl[5] = 16'sd3;
      ex_from_lv();
      write_all();
      start_group(4'd2, 4'd5, 1'b1, 1'b0);
      valid_in = 1'b1; position_in = 4'd2; coef_in = 16'sd9; delta_in = 16'sd0;
      @(posedge clk); #1;
      valid_in = 1'b0;
      drain();

      // Even parity, positive sign: flag set, no change.
      clear_vec();
      lv[0] = 16'sd3; lv[6] = 16'sd1; dl[6] = 16'sd2;
      ex_from_lv();
      write_all();
      start_group(4'd0, 4'd6, 1'b1, 1'b1);
      drain();

      // Mismatch: costs -6 / -8 / 0, scan3 (-1) drops to 0.
      clear_vec();
      lv[0] = 16'sd2;  dl[0] = 16'sd0;
      lv[3] = -16'sd1; dl[3] = -16'sd8;
      lv[5] = 16'sd2;  dl[5] = 16'sd6;
      ex_from_lv(); ex[3] = 16'sd0;
      write_all();
      start_group(4'd0, 4'd5, 1'b1, 1'b1);
      drain();

      // Tie at cost -4: higher scan index (7) wins and becomes +2.
      clear_vec();
      lv[0] = 16'sd1;
      lv[2] = 16'sd1; dl[2] = 16'sd4;
      lv[7] = 16'sd1; dl[7] = 16'sd4;
      ex_from_lv(); ex[7] = 16'sd2;
      write_all();
      start_group(4'd0, 4'd7, 1'b1, 1'b1);
      drain();

      // Only pos 1 rewritten: other entries keep prior (adjusted) contents.
      for (int i = 0; i < 16; i++) ex[i] = '0;
      ex[0] = 16'sd1; ex[2] = 16'sd1; ex[7] = 16'sd2; ex[1] = -16'sd5;
      write_one(4'd1, -16'sd5, 16'sd7);
      start_group(4'd0, 4'd0, 1'b0, 1'b0);
      drain();

      // Reversed scan, span exactly 4, negative hidden sign, raster 11 goes +2 -> +3.
      for (int i = 0; i < 16; i++) scan_order[i] = 4'(15 - i);
      clear_vec();
      lv[15] = -16'sd2; dl[15] = -16'sd3;
      lv[11] = 16'sd2;  dl[11] = 16'sd5;
      ex_from_lv(); ex[11] = 16'sd3;
      write_all();
      start_group(4'd0, 4'd4, 1'b1, 1'b1);
      drain();

      // Backpressure on beat 4, then reset at beat 9.
      just_done();
      start_group(4'd0, 4'd0, 1'b0, 1'b0);
      wait_beat(4'd4);
      out_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      wait_beat(4'd9);
      rst = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      check("midrst_valid_out", 32'(valid_out), 32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      check("midrst_pos_out",   32'(pos_out),   32'd0);
      check("midrst_sbh_flag",  32'(sbh_flag),  32'd0);
      exp_q.delete();
      lat_armed = 1'b0;
      rst = 1'b0; out_ready = 1'b1;
      repeat (25) begin @(posedge clk); #1; end

      // Storage cleared by reset: empty load yields all zeros.
      for (int i = 0; i < 16; i++) ex[i] = '0;
      just_done();
      start_group(4'd0, 4'd0, 1'b0, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
